// File: rtl/mbscore_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : mbscore_ctrl_mc
// Brief    : Multicycle control FSM for the MBScore MIPS-subset core.
// Revision : 1.0 - initial release
// ============================================================================
module mbscore_ctrl_mc #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15,
  parameter int MDU_ENABLE     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     inst,
  input  logic                      imem_ack,
  input  logic                      dmem_ack,
  input  logic                      mdu_done,
  output logic                      imem_req,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic                      pc_we,
  output logic                      ir_we,
  output logic                      br_en,
  output logic                      mdu_start,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0]                wb_sel,
  output logic [1:0]                alu_sel_a,
  output logic [1:0]                alu_sel_b,
  output logic [3:0]                alu_op,
  output logic [REG_ADDR_WIDTH-1:0] rs_addr,
  output logic [REG_ADDR_WIDTH-1:0] rt_addr,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [15:0]               imm,
  output logic [25:0]               jump_addr,
  output logic                      halted,
  output logic                      mem_err,
  output logic [3:0]                state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_IF  = 4'd1, S_ID = 4'd2, S_EXE  = 4'd3, S_MDU = 4'd4,
    S_MEM  = 4'd5, S_WB  = 4'd6, S_HALT = 4'd7, S_ERR = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    K_NOP = 4'd0, K_ALU = 4'd1, K_BR  = 4'd2, K_LD  = 4'd3, K_ST = 4'd4,
    K_MDU = 4'd5, K_J   = 4'd6, K_JAL = 4'd7, K_HLT = 4'd8
  } kind_t;

  localparam logic [3:0] c_alu_add = 4'd0,  c_alu_sub = 4'd1,  c_alu_and = 4'd2;
  localparam logic [3:0] c_alu_or  = 4'd3,  c_alu_xor = 4'd4,  c_alu_nor = 4'd5;
  localparam logic [3:0] c_alu_lt  = 4'd6,  c_alu_ltu = 4'd7,  c_alu_sll = 4'd8;
  localparam logic [3:0] c_alu_srl = 4'd9,  c_alu_sra = 4'd10, c_alu_eq  = 4'd11;
  localparam logic [3:0] c_alu_ne  = 4'd12;

  localparam int              c_cnt_w    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);
  localparam logic            c_mdu_en   = (MDU_ENABLE != 0);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [5:0]                w_opcode;
  logic [5:0]                w_funct;
  logic [REG_ADDR_WIDTH-1:0] w_rt;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  kind_t                     w_kind;
  logic [3:0]                w_op;
  logic [1:0]                w_sa;
  logic [1:0]                w_sb;

  assign w_opcode = inst[31:26];
  assign w_funct  = inst[5:0];
  assign w_rt     = inst[16 +: REG_ADDR_WIDTH];
  assign w_rd     = inst[11 +: REG_ADDR_WIDTH];

  // Instruction class plus ALU controls; anything unrecognised decodes as NOP.
  always_comb begin
    w_kind = K_NOP;
    w_op   = c_alu_add;
    w_sa   = 2'd0;
    w_sb   = 2'd0;
    case (w_opcode)
      6'h00: begin
        w_kind = K_ALU;
        case (w_funct)
          6'h20, 6'h21: w_op = c_alu_add;
          6'h22, 6'h23: w_op = c_alu_sub;
          6'h24:        w_op = c_alu_and;
          6'h25:        w_op = c_alu_or;
          6'h26:        w_op = c_alu_xor;
          6'h27:        w_op = c_alu_nor;
          6'h2A:        w_op = c_alu_lt;
          6'h2B:        w_op = c_alu_ltu;
          6'h00:        begin w_op = c_alu_sll; w_sa = 2'd1; end
          6'h02:        begin w_op = c_alu_srl; w_sa = 2'd1; end
          6'h03:        begin w_op = c_alu_sra; w_sa = 2'd1; end
          6'h08:        w_kind = K_J;
          6'h18, 6'h1A: w_kind = K_MDU;
          default:      w_kind = K_NOP;
        endcase
      end
      6'h02: w_kind = K_J;
      6'h03: w_kind = K_JAL;
      6'h04: begin w_kind = K_BR;  w_op = c_alu_eq; end
      6'h05: begin w_kind = K_BR;  w_op = c_alu_ne; end
      6'h08, 6'h09: begin w_kind = K_ALU; w_op = c_alu_add; w_sb = 2'd1; end
      6'h0A: begin w_kind = K_ALU; w_op = c_alu_lt;  w_sb = 2'd1; end
      6'h0B: begin w_kind = K_ALU; w_op = c_alu_ltu; w_sb = 2'd1; end
      6'h0C: begin w_kind = K_ALU; w_op = c_alu_and; w_sb = 2'd2; end
      6'h0D: begin w_kind = K_ALU; w_op = c_alu_or;  w_sb = 2'd2; end
      6'h0E: begin w_kind = K_ALU; w_op = c_alu_xor; w_sb = 2'd2; end
      6'h23: begin w_kind = K_LD;  w_sb = 2'd1; end
      6'h2B: begin w_kind = K_ST;  w_sb = 2'd1; end
      6'h3F: w_kind = K_HLT;
      default: w_kind = K_NOP;
    endcase
  end

  // Counter defaults to zero so every state change clears it; only waits count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_IDLE: r_state <= S_IF;
        S_IF: begin
          if (imem_ack)                r_state <= S_ID;
          else if (r_cnt == c_cnt_last) r_state <= S_ERR;
          else                         r_cnt   <= r_cnt + c_cnt_w'(1);
        end
        S_ID: begin
          case (w_kind)
            K_J, K_JAL, K_NOP: r_state <= S_IF;
            K_HLT:             r_state <= S_HALT;
            default:           r_state <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (w_kind)
            K_ALU:      r_state <= S_WB;
            K_LD, K_ST: r_state <= S_MEM;
            K_MDU:      r_state <= c_mdu_en ? S_MDU : S_IF;
            default:    r_state <= S_IF;
          endcase
        end
        S_MDU: if (mdu_done) r_state <= S_IF;
        S_MEM: begin
          if (dmem_ack)                r_state <= (w_kind == K_ST) ? S_IF : S_WB;
          else if (r_cnt == c_cnt_last) r_state <= S_ERR;
          else                         r_cnt   <= r_cnt + c_cnt_w'(1);
        end
        S_WB:   r_state <= S_IF;
        S_HALT: r_state <= S_HALT;
        S_ERR:  r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    br_en     = 1'b0;
    mdu_start = 1'b0;
    reg_we    = 1'b0;
    wr_addr   = '0;
    wb_sel    = 2'd0;
    alu_sel_a = 2'd0;
    alu_sel_b = 2'd0;
    alu_op    = 4'd0;
    halted    = 1'b0;
    mem_err   = 1'b0;
    if (r_state inside {S_ID, S_EXE, S_MEM, S_WB}) begin
      alu_sel_a = w_sa;
      alu_sel_b = w_sb;
      alu_op    = w_op;
    end
    case (r_state)
      S_IF: begin
        imem_req = 1'b1;
        pc_we    = imem_ack;
        ir_we    = imem_ack;
      end
      S_ID: begin
        if (w_kind == K_J) pc_we = 1'b1;
        if (w_kind == K_JAL) begin
          pc_we   = 1'b1;
          reg_we  = 1'b1;
          wr_addr = '1;
          wb_sel  = 2'd2;
        end
      end
      S_EXE: begin
        br_en     = (w_kind == K_BR);
        mdu_start = (w_kind == K_MDU) && c_mdu_en;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_kind == K_ST);
      end
      S_WB: begin
        reg_we  = 1'b1;
        wr_addr = (w_opcode == 6'h00) ? w_rd : w_rt;
        wb_sel  = (w_kind == K_LD) ? 2'd1 : 2'd0;
      end
      S_HALT: halted  = 1'b1;
      S_ERR:  mem_err = 1'b1;
      default: ;
    endcase
  end

  // Field taps read zero while in reset so the whole port set is quiet.
  assign rs_addr   = (r_state == S_IDLE) ? '0 : inst[21 +: REG_ADDR_WIDTH];
  assign rt_addr   = (r_state == S_IDLE) ? '0 : w_rt;
  assign rd_addr   = (r_state == S_IDLE) ? '0 : w_rd;
  assign imm       = (r_state == S_IDLE) ? '0 : inst[15:0];
  assign jump_addr = (r_state == S_IDLE) ? '0 : inst[25:0];
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mbscore_ctrl_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mbscore_ctrl_mc
// Brief    : Self-checking bench for mbscore_ctrl_mc with a cycle-plan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbscore_ctrl_mc;

  localparam int T_A = 15;
  localparam int T_B = 3;

  typedef struct packed {
    logic [3:0] state;
    logic       imem_req, dmem_req, dmem_we, pc_we, ir_we, br_en, mdu_start, reg_we;
    logic [4:0] wr_addr;
    logic [1:0] wb_sel, sel_a, sel_b;
    logic [3:0] alu_op;
    logic       halted, mem_err;
  } out_t;

  typedef struct { out_t o; logic ia; logic da; logic md; } step_t;
  typedef enum int {C_NOP, C_ALU, C_BR, C_LD, C_ST, C_MDU, C_J, C_JAL, C_HLT} cls_t;
  typedef struct { cls_t cls; logic [3:0] op; logic [1:0] sa; logic [1:0] sb; } info_t;

  localparam logic [5:0] R_FN [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                        6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h18, 6'h1A, 6'h3F};
  localparam logic [5:0] I_OP [0:14] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                        6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h10, 6'h3F};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, use_b;
  logic [31:0] inst;
  logic        imem_ack, dmem_ack, mdu_done;

  logic        a_imem_req, a_dmem_req, a_dmem_we, a_pc_we, a_ir_we, a_br_en, a_mdu_start, a_reg_we;
  logic [4:0]  a_wr_addr, a_rs, a_rt, a_rd;
  logic [1:0]  a_wb_sel, a_sel_a, a_sel_b;
  logic [3:0]  a_alu_op, a_state;
  logic [15:0] a_imm;
  logic [25:0] a_jump;
  logic        a_halted, a_mem_err;

  logic        b_imem_req, b_dmem_req, b_dmem_we, b_pc_we, b_ir_we, b_br_en, b_mdu_start, b_reg_we;
  logic [4:0]  b_wr_addr, b_rs, b_rt, b_rd;
  logic [1:0]  b_wb_sel, b_sel_a, b_sel_b;
  logic [3:0]  b_alu_op, b_state;
  logic [15:0] b_imm;
  logic [25:0] b_jump;
  logic        b_halted, b_mem_err;

  mbscore_ctrl_mc #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_TIMEOUT(T_A), .MDU_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_a), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .mdu_done(mdu_done), .imem_req(a_imem_req), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
    .pc_we(a_pc_we), .ir_we(a_ir_we), .br_en(a_br_en), .mdu_start(a_mdu_start), .reg_we(a_reg_we),
    .wr_addr(a_wr_addr), .wb_sel(a_wb_sel), .alu_sel_a(a_sel_a), .alu_sel_b(a_sel_b),
    .alu_op(a_alu_op), .rs_addr(a_rs), .rt_addr(a_rt), .rd_addr(a_rd), .imm(a_imm),
    .jump_addr(a_jump), .halted(a_halted), .mem_err(a_mem_err), .state(a_state));

  mbscore_ctrl_mc #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_TIMEOUT(T_B), .MDU_ENABLE(0)) dut_nomdu (
    .clk(clk), .rst_n(rst_b), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .mdu_done(mdu_done), .imem_req(b_imem_req), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
    .pc_we(b_pc_we), .ir_we(b_ir_we), .br_en(b_br_en), .mdu_start(b_mdu_start), .reg_we(b_reg_we),
    .wr_addr(b_wr_addr), .wb_sel(b_wb_sel), .alu_sel_a(b_sel_a), .alu_sel_b(b_sel_b),
    .alu_op(b_alu_op), .rs_addr(b_rs), .rt_addr(b_rt), .rd_addr(b_rd), .imm(b_imm),
    .jump_addr(b_jump), .halted(b_halted), .mem_err(b_mem_err), .state(b_state));

  out_t        obs;
  logic [56:0] obs_f;

  always_comb begin
    if (use_b) begin
      obs   = {b_state, b_imem_req, b_dmem_req, b_dmem_we, b_pc_we, b_ir_we, b_br_en, b_mdu_start,
               b_reg_we, b_wr_addr, b_wb_sel, b_sel_a, b_sel_b, b_alu_op, b_halted, b_mem_err};
      obs_f = {b_rs, b_rt, b_rd, b_imm, b_jump};
    end else begin
      obs   = {a_state, a_imem_req, a_dmem_req, a_dmem_we, a_pc_we, a_ir_we, a_br_en, a_mdu_start,
               a_reg_we, a_wr_addr, a_wb_sel, a_sel_a, a_sel_b, a_alu_op, a_halted, a_mem_err};
      obs_f = {a_rs, a_rt, a_rd, a_imm, a_jump};
    end
  end

  int      checks;
  int      failures;
  int      cur_t;
  bit      cur_mdu;
  bit      term;
  step_t   q[$];

  function automatic info_t mk(cls_t c, int op, int sa, int sb);
    info_t d;
    d.cls = c; d.op = 4'(op); d.sa = 2'(sa); d.sb = 2'(sb);
    return d;
  endfunction

  // Instruction-set table: class and ALU controls per opcode/funct.
  function automatic info_t decode(logic [31:0] x);
    info_t d;
    d = mk(C_NOP, 0, 0, 0);
    if (x[31:26] == 6'h00) begin
      case (x[5:0])
        6'h20, 6'h21: d = mk(C_ALU, 0, 0, 0);
        6'h22, 6'h23: d = mk(C_ALU, 1, 0, 0);
        6'h24: d = mk(C_ALU, 2, 0, 0);
        6'h25: d = mk(C_ALU, 3, 0, 0);
        6'h26: d = mk(C_ALU, 4, 0, 0);
        6'h27: d = mk(C_ALU, 5, 0, 0);
        6'h2A: d = mk(C_ALU, 6, 0, 0);
        6'h2B: d = mk(C_ALU, 7, 0, 0);
        6'h00: d = mk(C_ALU, 8, 1, 0);
        6'h02: d = mk(C_ALU, 9, 1, 0);
        6'h03: d = mk(C_ALU, 10, 1, 0);
        6'h08: d = mk(C_J, 0, 0, 0);
        6'h18, 6'h1A: d = mk(C_MDU, 0, 0, 0);
        default: ;
      endcase
    end else begin
      case (x[31:26])
        6'h02: d = mk(C_J, 0, 0, 0);
        6'h03: d = mk(C_JAL, 0, 0, 0);
        6'h04: d = mk(C_BR, 11, 0, 0);
        6'h05: d = mk(C_BR, 12, 0, 0);
        6'h08, 6'h09: d = mk(C_ALU, 0, 0, 1);
        6'h0A: d = mk(C_ALU, 6, 0, 1);
        6'h0B: d = mk(C_ALU, 7, 0, 1);
        6'h0C: d = mk(C_ALU, 2, 0, 2);
        6'h0D: d = mk(C_ALU, 3, 0, 2);
        6'h0E: d = mk(C_ALU, 4, 0, 2);
        6'h23: d = mk(C_LD, 0, 0, 1);
        6'h2B: d = mk(C_ST, 0, 0, 1);
        6'h3F: d = mk(C_HLT, 0, 0, 0);
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic out_t base(int st);
    out_t o;
    o = '0;
    o.state = 4'(st);
    return o;
  endfunction

  function automatic out_t with_alu(out_t o, info_t d);
    out_t r;
    r = o; r.sel_a = d.sa; r.sel_b = d.sb; r.alu_op = d.op;
    return r;
  endfunction

  function automatic void push(out_t o, logic ia, logic da, logic md);
    step_t s;
    s.o = o; s.ia = ia; s.da = da; s.md = md;
    q.push_back(s);
  endfunction

  function automatic void push_stuck(int st);
    out_t o;
    o = base(st);
    if (st == 8) o.mem_err = 1'b1; else o.halted = 1'b1;
    for (int k = 0; k < 3; k++) push(o, 1'($urandom), 1'($urandom), 1'($urandom));
    term = 1'b1;
  endfunction

  // Cycle-by-cycle plan: iw/dw = wait cycles before ack, mw = MDU cycles until done.
  task automatic plan(logic [31:0] x, int iw, int dw, int mw);
    info_t d;
    out_t  o;
    d = decode(x);
    term = 1'b0;
    for (int k = 0; k < cur_t; k++) begin
      o = base(1); o.imem_req = 1'b1;
      if (k == iw) begin
        o.pc_we = 1'b1; o.ir_we = 1'b1;
        push(o, 1'b1, 1'($urandom), 1'b0);
        break;
      end
      push(o, 1'b0, 1'($urandom), 1'($urandom));
    end
    if (iw >= cur_t) begin push_stuck(8); return; end
    o = with_alu(base(2), d);
    case (d.cls)
      C_J:   begin o.pc_we = 1'b1; push(o, 0, 0, 0); return; end
      C_JAL: begin
        o.pc_we = 1'b1; o.reg_we = 1'b1; o.wr_addr = 5'd31; o.wb_sel = 2'd2;
        push(o, 0, 0, 0); return;
      end
      C_NOP: begin push(o, 0, 0, 0); return; end
      C_HLT: begin push(o, 0, 0, 0); push_stuck(7); return; end
      default: push(o, 0, 0, 0);
    endcase
    o = with_alu(base(3), d);
    case (d.cls)
      C_BR: begin o.br_en = 1'b1; push(o, 0, 0, 0); return; end
      C_MDU: begin
        o.mdu_start = cur_mdu;
        push(o, 0, 0, 0);
        if (cur_mdu)
          for (int k = 1; k <= mw; k++) push(base(4), 1'($urandom), 1'($urandom), k == mw);
        return;
      end
      C_LD, C_ST: begin
        push(o, 0, 0, 0);
        for (int k = 0; k < cur_t; k++) begin
          o = with_alu(base(5), d); o.dmem_req = 1'b1; o.dmem_we = (d.cls == C_ST);
          if (k == dw) begin push(o, 1'($urandom), 1'b1, 1'b0); break; end
          push(o, 1'($urandom), 1'b0, 1'b0);
        end
        if (dw >= cur_t) begin push_stuck(8); return; end
        if (d.cls == C_ST) return;
      end
      default: push(o, 0, 0, 0);
    endcase
    o = with_alu(base(6), d);
    o.reg_we  = 1'b1;
    o.wr_addr = (x[31:26] == 6'h00) ? x[15:11] : x[20:16];
    o.wb_sel  = (d.cls == C_LD) ? 2'd1 : 2'd0;
    push(o, 0, 0, 0);
  endtask

  task automatic execute(logic [31:0] x, string name, int max_steps);
    step_t s;
    int    n;
    n = 0;
    while (q.size() > 0 && n < max_steps) begin
      s = q.pop_front();
      @(negedge clk);
      if (n == 0) inst = x;
      imem_ack = s.ia; dmem_ack = s.da; mdu_done = s.md;
      #1;
      checks++;
      if (obs !== s.o) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs got %h required %h", name, n, obs, s.o);
      end
      if (s.o.state == 4'd2) begin
        checks++;
        if (obs_f !== {x[25:21], x[20:16], x[15:11], x[15:0], x[25:0]}) begin
          failures++;
          $display("FAIL %s_fields: got %h required %h", name, obs_f,
                   {x[25:21], x[20:16], x[15:11], x[15:0], x[25:0]});
        end
      end
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    if (use_b) rst_b = 1'b0; else rst_a = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || obs_f !== '0) begin
      failures++;
      $display("FAIL %s_assert: got %h/%h required 0", name, obs, obs_f);
    end
    repeat (2) @(negedge clk);
    if (use_b) rst_b = 1'b1; else rst_a = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL %s_release_idle: got %h required 0", name, obs);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 31);
    if (k < 17) begin
      r[31:26] = 6'h00;
      r[5:0]   = R_FN[k];
    end else begin
      r[31:26] = I_OP[k - 17];
    end
    return r;
  endfunction

  task automatic test_reset();
    do_reset("reset");
    plan(32'h8C250004, 0, 10, 0);
    execute(32'h8C250004, "reset_pre_mem", 5);
    #2 rst_a = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || obs_f !== '0) begin
      failures++;
      $display("FAIL reset_mid_mem: got %h/%h required 0", obs, obs_f);
    end
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_mid_mem_release: got %h required 0", obs);
    end
    plan(32'h00221820, 0, 0, 0);
    execute(32'h00221820, "reset_then_add", 100);
  endtask

  task automatic test_alu();
    plan(32'h00221820, 0, 0, 0);      execute(32'h00221820, "add", 100);
    plan(32'h00031140, 2, 0, 0);      execute(32'h00031140, "sll", 100);
    plan(32'h3422FFFF, 1, 0, 0);      execute(32'h3422FFFF, "ori", 100);
    plan(32'h1022FFFE, 0, 0, 0);      execute(32'h1022FFFE, "beq", 100);
  endtask

  task automatic test_lw();
    plan(32'h8C250004, 0, 3, 0);      execute(32'h8C250004, "lw_ack4", 100);
  endtask

  task automatic test_sw_timeout();
    plan(32'hAC250004, 0, T_A - 1, 0); execute(32'hAC250004, "sw_ack_last", 100);
    plan(32'hAC250004, 0, T_A, 0);     execute(32'hAC250004, "sw_timeout", 100);
    do_reset("sw_err_reset");
    plan(32'h00221820, T_A, 0, 0);     execute(32'h00221820, "if_timeout", 100);
    do_reset("if_err_reset");
  endtask

  task automatic test_mult();
    plan(32'h00220018, 0, 0, 7);      execute(32'h00220018, "mult", 100);
    plan(32'h0022001A, 1, 0, 3);      execute(32'h0022001A, "div", 100);
  endtask

  task automatic test_jal_halt();
    plan(32'h0C000010, 0, 0, 0);      execute(32'h0C000010, "jal", 100);
    plan(32'h08000020, 0, 0, 0);      execute(32'h08000020, "j", 100);
    plan(32'hFC000000, 0, 0, 0);      execute(32'hFC000000, "hlt", 100);
    do_reset("hlt_reset");
  endtask

  task automatic test_mdu_disabled();
    @(negedge clk);
    rst_a = 1'b0;
    use_b = 1'b1; cur_t = T_B; cur_mdu = 1'b0;
    do_reset("nomdu_reset");
    plan(32'h00220018, 0, 0, 7);      execute(32'h00220018, "nomdu_mult", 100);
    plan(32'h8C250004, 0, T_B - 1, 0); execute(32'h8C250004, "nomdu_lw_last", 100);
    plan(32'h8C250004, 0, T_B, 0);     execute(32'h8C250004, "nomdu_lw_timeout", 100);
    do_reset("nomdu_err_reset");
    @(negedge clk);
    rst_b = 1'b0;
    use_b = 1'b0; cur_t = T_A; cur_mdu = 1'b1;
    do_reset("back_to_a");
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    int          iw, dw, mw;
    for (int i = 0; i < 60; i++) begin
      x  = rand_inst();
      iw = ($urandom_range(0, 19) == 0) ? cur_t : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 19) == 0) ? cur_t : int'($urandom_range(0, 3));
      mw = $urandom_range(1, 6);
      plan(x, iw, dw, mw);
      execute(x, "random", 1000);
      if (term) do_reset("random_recover");
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    use_b = 1'b0; cur_t = T_A; cur_mdu = 1'b1; term = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    inst = '0; imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_alu();
    test_lw();
    test_sw_timeout();
    test_mult();
    test_jal_halt();
    test_mdu_disabled();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
